// File: rtl/updown_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_bcd_counter
// Description : Two-digit BCD up/down counter stepped once per rising edge of
//               a slow pulse-divider square wave. Direction, enable and clear
//               are asynchronous board inputs and are brought into the clock
//               domain with 2-FF synchronisers. Counting either wraps modulo
//               MAX_COUNT+1 or saturates at 0 / MAX_COUNT.
//
// Parameters  : MAX_COUNT - upper count limit in decimal (1..99)
//               WRAP      - 1 = wrap around at the limits, 0 = saturate
//
// Ports       : I_CLK   in   system clock (50 MHz)
//               I_RST   in   synchronous reset, active-high
//               I_PULSE in   slow square wave, already in the I_CLK domain
//               I_DIR   in   async switch, 1 = up, 0 = down
//               I_EN    in   async switch, 1 = counting enabled
//               I_CLR   in   async button, active-high clear to 00
//               O_ONES  out  BCD ones digit
//               O_TENS  out  BCD tens digit
//               O_TC    out  one-cycle terminal-count strobe
//
// Revision    : 1.0 - initial release
// ============================================================================
module updown_bcd_counter #(
    parameter int unsigned MAX_COUNT = 99,
    parameter bit          WRAP      = 1'b1
) (
    input  logic       I_CLK,
    input  logic       I_RST,
    input  logic       I_PULSE,
    input  logic       I_DIR,
    input  logic       I_EN,
    input  logic       I_CLR,
    output logic [3:0] O_ONES,
    output logic [3:0] O_TENS,
    output logic       O_TC
);

    // Limit split into its decimal digits so compares stay digit-wise.
    localparam logic [3:0] c_max_tens = 4'(MAX_COUNT / 10);
    localparam logic [3:0] c_max_ones = 4'(MAX_COUNT % 10);

    // Synchroniser bit positions
    localparam int c_sw_dir = 0;
    localparam int c_sw_en  = 1;
    localparam int c_sw_clr = 2;

    logic [2:0] r_sw_meta;
    logic [2:0] r_sw_sync;
    logic       r_pulse_q;
    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       r_tc;

    logic       w_tick;
    logic       w_dir;
    logic       w_en;
    logic       w_clr;
    logic       w_at_max;
    logic       w_at_zero;
    logic [3:0] w_ones_nxt;
    logic [3:0] w_tens_nxt;
    logic       w_tc_nxt;

    // ------------------------------------------------------------------
    // Switch synchronisers and pulse history
    // ------------------------------------------------------------------
    // The pulse history resets to 1 so a pulse that is already high when
    // reset releases is not mistaken for a fresh rising edge.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_sw_meta <= 3'b000;
            r_sw_sync <= 3'b000;
            r_pulse_q <= 1'b1;
        end else begin
            r_sw_meta <= {I_CLR, I_EN, I_DIR};
            r_sw_sync <= r_sw_meta;
            r_pulse_q <= I_PULSE;
        end
    end

    assign w_dir  = r_sw_sync[c_sw_dir];
    assign w_en   = r_sw_sync[c_sw_en];
    assign w_clr  = r_sw_sync[c_sw_clr];
    assign w_tick = I_PULSE & ~r_pulse_q;

    assign w_at_max  = (r_tens == c_max_tens) && (r_ones == c_max_ones);
    assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

    // ------------------------------------------------------------------
    // Digit-wise next-state logic; clear beats a coincident tick.
    // ------------------------------------------------------------------
    always_comb begin
        w_ones_nxt = r_ones;
        w_tens_nxt = r_tens;
        w_tc_nxt   = 1'b0;
        if (w_clr) begin
            w_ones_nxt = 4'd0;
            w_tens_nxt = 4'd0;
        end else if (w_tick && w_en) begin
            if (w_dir) begin
                if (w_at_max) begin
                    w_tc_nxt = 1'b1;
                    if (WRAP) begin
                        w_ones_nxt = 4'd0;
                        w_tens_nxt = 4'd0;
                    end
                end else if (r_ones == 4'd9) begin
                    w_ones_nxt = 4'd0;
                    w_tens_nxt = r_tens + 4'd1;
                end else begin
                    w_ones_nxt = r_ones + 4'd1;
                end
            end else begin
                if (w_at_zero) begin
                    w_tc_nxt = 1'b1;
                    if (WRAP) begin
                        w_ones_nxt = c_max_ones;
                        w_tens_nxt = c_max_tens;
                    end
                end else if (r_ones == 4'd0) begin
                    w_ones_nxt = 4'd9;
                    w_tens_nxt = r_tens - 4'd1;
                end else begin
                    w_ones_nxt = r_ones - 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Count state
    // ------------------------------------------------------------------
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
            r_tc   <= 1'b0;
        end else begin
            r_ones <= w_ones_nxt;
            r_tens <= w_tens_nxt;
            r_tc   <= w_tc_nxt;
        end
    end

    assign O_ONES = r_ones;
    assign O_TENS = r_tens;
    assign O_TC   = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_updown_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_bcd_counter
// Description : Scoreboard bench for updown_bcd_counter. Instance 0 runs with
//               MAX_COUNT=99/WRAP=1, instance 1 with MAX_COUNT=59/WRAP=0.
//               Stimulus pushes the expected value and arrival cycle of each
//               output change; a negedge monitor pops and compares whenever a
//               digit changes or the terminal-count strobe is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_bcd_counter;

    typedef struct {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       tc;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst   [2];
    logic       pulse [2];
    logic       dir   [2];
    logic       en    [2];
    logic       clr   [2];
    logic [3:0] ones  [2];
    logic [3:0] tens  [2];
    logic       tc    [2];

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] prev_d [2];

    int d_m    [2];
    int max_m  [2] = '{99, 59};
    bit wrap_m [2] = '{1'b1, 1'b0};

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    updown_bcd_counter #(.MAX_COUNT(99), .WRAP(1'b1)) u_dut_wrap (
        .I_CLK(clk), .I_RST(rst[0]), .I_PULSE(pulse[0]), .I_DIR(dir[0]),
        .I_EN(en[0]), .I_CLR(clr[0]),
        .O_ONES(ones[0]), .O_TENS(tens[0]), .O_TC(tc[0])
    );

    updown_bcd_counter #(.MAX_COUNT(59), .WRAP(1'b0)) u_dut_sat (
        .I_CLK(clk), .I_RST(rst[1]), .I_PULSE(pulse[1]), .I_DIR(dir[1]),
        .I_EN(en[1]), .I_CLR(clr[1]),
        .O_ONES(ones[1]), .O_TENS(tens[1]), .O_TC(tc[1])
    );

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                if ({tens[i], ones[i]} != prev_d[i] || tc[i] === 1'b1) begin
                    have = 1'b0;
                    if (i == 0 && q0.size() > 0) begin
                        e = q0.pop_front(); have = 1'b1;
                    end else if (i == 1 && q1.size() > 0) begin
                        e = q1.pop_front(); have = 1'b1;
                    end
                    checks++;
                    if (!have) begin
                        errors++;
                        $display("FAIL sb_dut%0d unexpected: got %0d%0d tc=%0d @cyc %0d, want no change",
                                 i, tens[i], ones[i], tc[i], cyc);
                    end else if (tens[i] !== e.tens || ones[i] !== e.ones ||
                                 tc[i] !== e.tc || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL sb_dut%0d: got %0d%0d tc=%0d @cyc %0d, want %0d%0d tc=%0d @cyc %0d",
                                 i, tens[i], ones[i], tc[i], cyc, e.tens, e.ones, e.tc, e.cyc);
                    end
                end
                prev_d[i] = {tens[i], ones[i]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_exp(input int i, input int dval, input logic tcv, input int at);
        exp_t e;
        e.tens = 4'(dval / 10);
        e.ones = 4'(dval % 10);
        e.tc   = tcv;
        e.cyc  = at;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One full pulse period; the digits must move on the edge that first
    // samples the pulse high, i.e. one cycle after it is driven.
    task automatic tick(input int i);
        int   nd;
        logic t;
        pulse[i] = 1'b1;
        if (en[i]) begin
            nd = d_m[i];
            t  = 1'b0;
            if (dir[i]) begin
                if (nd == max_m[i]) begin
                    t = 1'b1;
                    if (wrap_m[i]) nd = 0;
                end else nd = nd + 1;
            end else begin
                if (nd == 0) begin
                    t = 1'b1;
                    if (wrap_m[i]) nd = max_m[i];
                end else nd = nd - 1;
            end
            d_m[i] = nd;
            push_exp(i, nd, t, cyc + 1);
        end
        step(3);
        pulse[i] = 1'b0;
        step(3);
    endtask

    task automatic chk(input string name, input int i, input int exp_d, input logic exp_tc);
        checks++;
        if (tens[i] !== 4'(exp_d / 10) || ones[i] !== 4'(exp_d % 10) || tc[i] !== exp_tc) begin
            errors++;
            $display("FAIL %s: got %0d%0d tc=%0d, want %0d tc=%0d",
                     name, tens[i], ones[i], tc[i], exp_d, exp_tc);
        end
    endtask

    task automatic set_sw(input int i, input logic d, input logic e);
        dir[i] = d;
        en[i]  = e;
        step(4);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; pulse[i] = 1'b1; dir[i] = 1'b1;
            en[i]  = 1'b0; clr[i]   = 1'b0; d_m[i] = 0;
        end
        step(4);
        chk("reset_wrap", 0, 0, 1'b0);
        chk("reset_sat", 1, 0, 1'b0);
        prev_d[0] = 8'h00;
        prev_d[1] = 8'h00;
        mon_on = 1'b1;

        // Pulse already high at release: no step may follow
        rst[0] = 1'b0; rst[1] = 1'b0;
        en[0]  = 1'b1; en[1]  = 1'b1;
        step(6);
        chk("release_hi_wrap", 0, 0, 1'b0);
        chk("release_hi_sat", 1, 0, 1'b0);
        pulse[0] = 1'b0; pulse[1] = 1'b0;
        step(3);

        // Up count to 12
        repeat (12) tick(0);
        chk("up_to_12", 0, 12, 1'b0);

        // Wrap at 99 both directions
        repeat (86) tick(0);
        chk("up_to_98", 0, 98, 1'b0);
        tick(0);                                    // 99
        tick(0);                                    // 00 with TC
        chk("wrap_up_00", 0, 0, 1'b0);
        set_sw(0, 1'b0, 1'b1);
        tick(0);                                    // 99 with TC
        chk("wrap_down_99", 0, 99, 1'b0);
        set_sw(0, 1'b1, 1'b1);
        tick(0);                                    // 00 with TC
        repeat (10) tick(0);                        // 10
        set_sw(0, 1'b0, 1'b1);
        tick(0);                                    // 09, digit borrow
        chk("borrow_09", 0, 9, 1'b0);

        // Clear coincident with a tick at 37
        set_sw(0, 1'b1, 1'b1);
        repeat (28) tick(0);
        chk("up_to_37", 0, 37, 1'b0);
        clr[0] = 1'b1;
        step(1);
        clr[0] = 1'b0;
        step(1);
        pulse[0] = 1'b1;                            // tick meets synced clear
        push_exp(0, 0, 1'b0, cyc + 1);
        d_m[0] = 0;
        step(3);
        pulse[0] = 1'b0;
        step(6);
        chk("clear_wins", 0, 0, 1'b0);

        // Disabled ticks are ignored
        set_sw(0, 1'b1, 1'b0);
        repeat (5) tick(0);
        chk("disabled", 0, 0, 1'b0);
        set_sw(0, 1'b1, 1'b1);

        // Reset coincident with a tick at 45
        repeat (45) tick(0);
        chk("up_to_45", 0, 45, 1'b0);
        rst[0]   = 1'b1;
        pulse[0] = 1'b1;
        push_exp(0, 0, 1'b0, cyc + 1);
        d_m[0] = 0;
        step(1);
        rst[0] = 1'b0;
        step(3);
        pulse[0] = 1'b0;
        step(3);
        tick(0);                                    // 01
        tick(0);                                    // 02
        chk("after_reset_02", 0, 2, 1'b0);

        // Saturating instance: hold at 59 with three TC pulses
        repeat (59) tick(1);
        chk("sat_up_59", 1, 59, 1'b0);
        repeat (3) tick(1);
        chk("sat_hold_59", 1, 59, 1'b0);
        set_sw(1, 1'b0, 1'b1);
        tick(1);
        chk("sat_down_58", 1, 58, 1'b0);

        step(10);
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL drain_wrap: got %0d pending, want 0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL drain_sat: got %0d pending, want 0", q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_bcd_counter.md
Name: updown_bcd_counter

Overview:
- Consumer stage directly downstream of the switch-selectable 1 Hz / 2 Hz pulse divider in the up/down counter design.
- Edge-detects the divider's slow square wave in the 50 MHz system clock domain and steps a two-digit BCD counter once per rising edge.
- Direction, enable and clear come from board switches/buttons and are synchronised internally.
- BCD digits feed the 7-segment display stage.

Parameters:
- MAX_COUNT, 99, upper count limit in decimal; legal range 1..99.
- WRAP, 1, 1 = modulo (MAX_COUNT+1) wrap-around; 0 = saturate at 0 / MAX_COUNT.

Ports:
- I_CLK  input  1  system clock, 50 MHz.
- I_RST  input  1  synchronous reset, active-high.
- I_PULSE  input  1  slow square wave from the pulse divider; I_CLK-domain register output.
- I_DIR  input  1  switch, asynchronous; 1 = count up, 0 = count down.
- I_EN  input  1  switch, asynchronous; 1 = counting enabled.
- I_CLR  input  1  button, asynchronous, active-high; clears count to 0.
- O_ONES  output  4  BCD ones digit, 0..9.
- O_TENS  output  4  BCD tens digit, 0..9.
- O_TC  output  1  terminal-count strobe, one I_CLK cycle wide.

Behaviour:

Clocking and reset
- Single clock domain; all state changes on the rising edge of I_CLK.
- I_RST is synchronous and active-high.
- Reset values:
  - O_ONES = 0, O_TENS = 0, O_TC = 0.
  - Switch synchronisers = 0.
  - Pulse history register = 1. This suppresses a spurious tick if I_PULSE is already high when reset is released.
- I_RST has priority over every other input.
- Reset mid-count: digits return to 00 on the next edge; any pending tick is discarded.

Switch synchronisation
- I_DIR, I_EN and I_CLR each pass through a 2-FF synchroniser.
- A switch change takes effect in the tick decision 2 cycles after it is sampled.
- No debounce is applied; the bench drives clean levels.

Tick detection
- tick = I_PULSE & ~pulse_q, where pulse_q is I_PULSE registered each cycle.
- The count updates on the same edge at which tick is evaluated true, so the digits change 1 cycle after I_PULSE is first sampled high.
- Exactly one tick per I_PULSE rising edge; falling edges are ignored.
- pulse_q updates every cycle regardless of I_EN or clear.

Count update, priority high to low (digit value D = 10*TENS + ONES)
1. I_RST → reset.
2. Synchronised clear → D = 0. Clear and tick in the same cycle: clear wins and the tick is lost.
3. tick & synchronised EN:
   - Up, D < MAX_COUNT → D+1. ONES wraps 9→0 with TENS+1.
   - Up, D = MAX_COUNT → D = 0 if WRAP = 1, else hold.
   - Down, D > 0 → D−1. ONES wraps 0→9 with TENS−1.
   - Down, D = 0 → D = MAX_COUNT if WRAP = 1, else hold.
4. Otherwise hold.
- The BCD digits are the state. No binary-to-BCD conversion is performed; increment and decrement are done digit-wise.
- Digits never hold a non-BCD value (A–F). D never exceeds MAX_COUNT.
- Direction is sampled at the tick, so a switch change between ticks only affects the next step.

O_TC
- Registered; asserts for exactly 1 cycle, on the same edge as the digit update, for each enabled, non-cleared tick taken at a limit (up at MAX_COUNT or down at 0).
- Asserts regardless of WRAP.
- 0 at all other times, including during clear and reset.

Test Plan:
1. Reset with I_PULSE held high, then release → O_ONES/O_TENS = 0/0, O_TC = 0, and no step occurs until I_PULSE falls and rises again.
2. EN = 1, DIR = 1, 12 rising edges of I_PULSE from 00 → digits read 12 (TENS = 1, ONES = 2). Each change lands exactly 1 cycle after I_PULSE rises; no change occurs on falling edges.
3. WRAP = 1, MAX_COUNT = 99:
   - Count up from 98 → 99, then 00 with O_TC high for 1 cycle.
   - DIR = 0 at 00 → 99 with O_TC pulse.
   - 10 → 09 checks the digit borrow.
4. WRAP = 0, MAX_COUNT = 59: count up to 59; 3 further ticks → holds 59 with 3 separate 1-cycle O_TC pulses. DIR = 0 → 58.
5. Clear asserted in the same cycle as a tick at D = 37 → 00 (no 38), O_TC = 0. EN = 0 with 5 ticks → count unchanged.
6. Assert I_RST mid-run at D = 45 for 1 cycle coincident with a tick → 00 on the next edge, then normal counting from 00 on subsequent ticks.
